// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave with Wishbone register file.
package i2c_slave_pkg;

  // Bus-side FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_IGNORE
  } state_t;

  // Register offsets, decoded from wb_adr_i[4:2]
  localparam logic [2:0] REG_ADDR   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_RXDATA = 3'd2;
  localparam logic [2:0] REG_TXDATA = 3'd3;

  // STATUS bit positions
  localparam int SB_RX_VALID = 0;
  localparam int SB_TX_EMPTY = 1;
  localparam int SB_BUSY     = 2;
  localparam int SB_RW       = 3;
  localparam int SB_OVERRUN  = 4;
  localparam int SB_UNDERRUN = 5;
  localparam int SB_STOP     = 6;

endpackage

// File: rtl/i2c_slave_phy.sv
// I2C bus side: SCL/SDA synchroniser, START/STOP detect, protocol FSM and shifter.
// Samples SDA on SCL rise, changes sda_oe only on SCL fall; never stretches SCL.
module i2c_slave_phy
  import i2c_slave_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  input  logic [6:0] own_addr,
  input  logic       enable,
  input  logic       rx_valid,
  input  logic       tx_empty,
  input  logic [7:0] tx_data,
  output logic       sda_oe,
  output logic       rx_wr,
  output logic [7:0] rx_byte,
  output logic       overrun_set,
  output logic       tx_load,
  output logic       stop_set,
  output logic       rw,
  output logic       busy
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic       oe_n, rw_n, hit, hit_n, load_tx;

  // Two-flop synchronisers plus one delayed copy for edge detection; idle bus is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign rx_byte = sh_n;
  assign busy    = (state != ST_IDLE) && (state != ST_IGNORE);

  // State and datapath registers; reset releases sda asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      sh     <= 8'd0;
      sda_oe <= 1'b0;
      rw     <= 1'b0;
      hit    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sh     <= sh_n;
      sda_oe <= oe_n;
      rw     <= rw_n;
      hit    <= hit_n;
    end
  end

  // Next-state logic; START/STOP override every state
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh_n        = sh;
    oe_n        = sda_oe;
    rw_n        = rw;
    hit_n       = hit;
    load_tx     = 1'b0;
    rx_wr       = 1'b0;
    overrun_set = 1'b0;
    tx_load     = 1'b0;
    stop_set    = 1'b0;
    if (stop_det) begin
      state_n  = ST_IDLE;
      oe_n     = 1'b0;
      stop_set = hit;
      hit_n    = 1'b0;
    end else if (start_det) begin
      state_n = ST_ADDR;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
      hit_n   = 1'b0;
    end else begin
      case (state)
        ST_ADDR: if (scl_rise) begin
          sh_n  = {sh[6:0], sda_s};
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            if ((sh_n[7:1] == own_addr) && enable) begin
              state_n = ST_ADDR_ACK;
              rw_n    = sh_n[0];
              hit_n   = 1'b1;
            end else begin
              state_n = ST_IGNORE;
            end
          end
        end
        // First fall starts the ACK low, second fall ends it
        ST_ADDR_ACK, ST_RX_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            oe_n = 1'b1;
          end else begin
            oe_n  = 1'b0;
            cnt_n = 4'd0;
            if (state == ST_ADDR_ACK && rw) load_tx = 1'b1;
            else                            state_n = ST_RX;
          end
        end
        ST_RX: if (scl_rise) begin
          sh_n  = {sh[6:0], sda_s};
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            if (!rx_valid) begin
              rx_wr   = 1'b1;
              state_n = ST_RX_ACK;
            end else begin
              overrun_set = 1'b1;
              state_n     = ST_IGNORE;
            end
          end
        end
        // Count bits on rises; on each fall present the next bit or release after 8
        ST_TX: begin
          if (scl_rise) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              oe_n    = 1'b0;
              state_n = ST_TX_ACK;
            end else begin
              sh_n = {sh[6:0], 1'b1};
              oe_n = ~sh[6];
            end
          end
        end
        // cnt=9 marks a sampled master ACK; the following fall starts the next byte
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_n = ST_IGNORE;
            else       cnt_n   = 4'd9;
          end else if (scl_fall && cnt == 4'd9) begin
            load_tx = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (load_tx) begin
      state_n = ST_TX;
      cnt_n   = 4'd0;
      tx_load = 1'b1;
      sh_n    = tx_empty ? 8'hFF : tx_data;
      oe_n    = ~sh_n[7];
    end
  end

endmodule

// File: rtl/i2c_slave_wb.sv
// I2C slave with a Wishbone register file (ADDR, STATUS, RXDATA, TXDATA).
module i2c_slave_wb
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] OWN_ADDR_RST = 7'h42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic        scl,
  inout  wire         sda,
  output logic        irq
);

  logic [6:0]  own_addr;
  logic        enable, rx_valid, tx_empty, overrun, underrun, stop_seen;
  logic [7:0]  rx_data, tx_data;
  logic        sda_oe, rx_wr, overrun_set, tx_load, stop_set, rw, busy;
  logic [7:0]  rx_byte;
  logic        acc, wr, rd;
  logic [2:0]  sel;
  logic [31:0] rdata;
  logic        unused_ok;

  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:8]};

  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign irq = rx_valid | stop_seen | overrun | underrun;

  i2c_slave_phy u_phy (
    .clk         (clk),
    .reset       (reset),
    .scl         (scl),
    .sda_in      (sda),
    .own_addr    (own_addr),
    .enable      (enable),
    .rx_valid    (rx_valid),
    .tx_empty    (tx_empty),
    .tx_data     (tx_data),
    .sda_oe      (sda_oe),
    .rx_wr       (rx_wr),
    .rx_byte     (rx_byte),
    .overrun_set (overrun_set),
    .tx_load     (tx_load),
    .stop_set    (stop_set),
    .rw          (rw),
    .busy        (busy)
  );

  // One access per strobe: masking with ack makes side effects happen exactly once
  assign acc = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr  = acc & wb_we_i;
  assign rd  = acc & ~wb_we_i;
  assign sel = wb_adr_i[4:2];

  // Read mux; undecoded offsets and unused bits read 0
  always_comb begin
    rdata = '0;
    case (sel)
      REG_ADDR:   rdata[7:0] = {enable, own_addr};
      REG_STATUS: begin
        rdata[SB_RX_VALID] = rx_valid;
        rdata[SB_TX_EMPTY] = tx_empty;
        rdata[SB_BUSY]     = busy;
        rdata[SB_RW]       = rw;
        rdata[SB_OVERRUN]  = overrun;
        rdata[SB_UNDERRUN] = underrun;
        rdata[SB_STOP]     = stop_seen;
      end
      REG_RXDATA: rdata[7:0] = rx_data;
      default: ;
    endcase
  end

  // Registered acknowledge and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= rd ? rdata : '0;
    end
  end

  // Configuration and transmit data written from Wishbone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_addr <= OWN_ADDR_RST;
      enable   <= 1'b1;
      tx_data  <= 8'd0;
    end else begin
      if (wr && sel == REG_ADDR)   {enable, own_addr} <= wb_dat_i[7:0];
      if (wr && sel == REG_TXDATA) tx_data <= wb_dat_i[7:0];
    end
  end

  // Status flags; a bus-side set wins over a same-cycle Wishbone clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_valid  <= 1'b0;
      rx_data   <= 8'd0;
      tx_empty  <= 1'b1;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      stop_seen <= 1'b0;
    end else begin
      if (rx_wr) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_byte;
      end else if (rd && sel == REG_RXDATA) begin
        rx_valid <= 1'b0;
      end
      if (tx_load)                      tx_empty <= 1'b1;
      else if (wr && sel == REG_TXDATA) tx_empty <= 1'b0;
      if (overrun_set)                                               overrun <= 1'b1;
      else if (wr && sel == REG_STATUS && wb_dat_i[SB_OVERRUN])      overrun <= 1'b0;
      if (tx_load && tx_empty)                                       underrun <= 1'b1;
      else if (wr && sel == REG_STATUS && wb_dat_i[SB_UNDERRUN])     underrun <= 1'b0;
      if (stop_set)                                                  stop_seen <= 1'b1;
      else if (wr && sel == REG_STATUS && wb_dat_i[SB_STOP])         stop_seen <= 1'b0;
    end
  end

endmodule

// File: doc/i2c_slave_wb.md
I2C_SLAVE_WB -- requirements
Module: i2c_slave_wb

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; every flop is on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port wb_adr_i, input, 32, Wishbone address; only [4:2] is decoded.
REQ-004 SHALL have port wb_dat_i, input, 32, Wishbone write data.
REQ-005 SHALL have port wb_dat_o, output, 32, Wishbone read data; unused bits read 0.
REQ-006 SHALL have port wb_sel_i, input, 4, ignored; every access is treated as 32-bit.
REQ-007 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i, input, 1 each, Wishbone controls.
REQ-008 SHALL have port wb_ack_o, output, 1, Wishbone acknowledge.
REQ-009 SHALL have port scl, input, 1, I2C clock from the bus master; the block never stretches SCL.
REQ-010 SHALL have port sda, inout, 1, open-drain: driven 0 when sda_oe=1, else 'z'.
REQ-011 SHALL have port irq, output, 1, interrupt = rx_valid | stop_seen | overrun | underrun.
REQ-012 SHALL have parameter OWN_ADDR_RST, default 7'h42, reset value of the own-address register.

Function
REQ-013 SHALL synchronise scl and sda through 2 flops and derive edges and levels from the synchronised copies; clk SHALL be at least 16x the SCL rate.
REQ-014 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high; both are recognised in every state.
REQ-015 SHALL implement FSM states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK and IGNORE.
REQ-016 SHALL, on START or repeated START, clear the bit counter, release sda and enter ADDR; on STOP it SHALL release sda, set stop_seen if the block was addressed, and enter IDLE.
REQ-017 SHALL sample SDA on SCL rising edges and change sda_oe only on SCL falling edges.
REQ-018 SHALL, in ADDR, shift 8 bits MSB-first; if bits[7:1] == own_addr and enable=1, it SHALL ACK in ADDR_ACK by driving 0 from the next SCL fall to the following fall; otherwise it SHALL enter IGNORE and leave sda released.
REQ-019 SHALL go from ADDR_ACK to RX when R/W=0, and to TX when R/W=1.
REQ-020 SHALL, in RX, shift 8 bits; when rx_valid=0 it SHALL copy the byte to RXDATA, set rx_valid and ACK in RX_ACK; when rx_valid=1 it SHALL discard the byte, set overrun, NACK (sda released) and enter IGNORE.
REQ-021 SHALL, entering TX, load the shift register from TXDATA and set tx_empty; if tx_empty was already set it SHALL send 8'hFF and set underrun.
REQ-022 SHALL drive bit 7 on the SCL fall that ends ADDR_ACK or the master ACK, and each later bit on later falls.
REQ-023 SHALL, after 8 TX bits, release sda and sample the master ACK in TX_ACK: 0 -> TX with the next byte; 1 -> IGNORE.
REQ-024 SHALL stay in IGNORE with sda released until START or STOP.
REQ-025 SHALL implement a register map on wb_adr_i[4:2]: 0 ADDR (RW; [6:0] own_addr, [7] enable); 1 STATUS (R; [0] rx_valid, [1] tx_empty, [2] busy = state is not IDLE or IGNORE, [3] last R/W, [4] overrun, [5] underrun, [6] stop_seen; writing 1 to bits 4-6 clears them); 2 RXDATA (R; a read clears rx_valid); 3 TXDATA (W; a write loads the byte and clears tx_empty); any other address reads 0 and ignores writes.
REQ-026 SHALL register wb_ack_o high in the cycle after stb&cyc and drop it after that one cycle; side effects SHALL occur once per access.
REQ-027 SHALL give priority to the bus event when a bus event and a Wishbone clear hit the same flag in the same cycle (the flag ends set).

Reset
REQ-028 SHALL, while reset=0, set: state=IDLE, sda_oe=0, wb_ack_o=0, wb_dat_o=0, irq=0, own_addr=OWN_ADDR_RST, enable=1, rx_valid=0, tx_empty=1, all error/stop flags=0, RXDATA=0, TXDATA=0.
REQ-029 SHALL, when reset asserts mid-transfer, release sda immediately (asynchronously); after reset the block SHALL ignore the bus until the next START.

Structure
REQ-030 SHALL place the FSM state enum, the register offsets and the STATUS bit indices in shared package i2c_slave_pkg.
REQ-031 SHALL implement the bus side in one sub-module, i2c_slave_phy (synchroniser, START/STOP detect, FSM, shifter); the Wishbone register file SHALL be in i2c_slave_wb.

Verification
REQ-032 SHALL test a write: own_addr=0x42; master sends 0x84 then 0xA5 then STOP -> both bytes ACKed, RXDATA=0xA5, rx_valid=1, stop_seen=1, irq=1.
REQ-033 SHALL test an address miss: master sends 0x86 then 0x11 -> sda never driven, state IGNORE, rx_valid stays 0.
REQ-034 SHALL test a read: TXDATA=0x3C; master sends 0x85, reads one byte, NACKs, STOP -> bus byte=0x3C, underrun=0, state IDLE.
REQ-035 SHALL test overrun: 0x84, 0x11, 0x22 with no RXDATA read -> 0x22 NACKed, overrun=1, RXDATA=0x11.
REQ-036 SHALL test underrun and repeated START: write 0x84, 0x55, then repeated START and 0x85 with TXDATA empty -> reads 0xFF, underrun=1, RXDATA=0x55.
REQ-037 SHALL test reset mid-transfer: reset=0 during the ACK bit of 0x84 -> sda released within the same cycle; all registers at reset values.
